// File: rtl/bp_io_wormhole_packet_assembler.sv
// IO NoC edge-port terminator: collects a wormhole header + body flits into one wide
// packet for the host-side consumer, draining and flagging packets that are too long.
module bp_io_wormhole_packet_assembler #(
  parameter  int flit_width_p     = 64,
  parameter  int cord_width_p     = 8,
  parameter  int len_width_p      = 4,
  parameter  int max_body_flits_p = 7,
  localparam int packet_width_lp  = flit_width_p * (max_body_flits_p + 1),
  localparam int link_width_lp    = flit_width_p + 2
) (
  input  logic                       io_clk_i,
  input  logic                       io_reset_n_i,
  input  logic [link_width_lp-1:0]   link_i,
  output logic [link_width_lp-1:0]   link_o,
  output logic [packet_width_lp-1:0] packet_o,
  output logic [len_width_p-1:0]     packet_len_o,
  output logic                       packet_v_o,
  input  logic                       packet_yumi_i,
  output logic                       err_o
);

  typedef struct packed {
    logic                    v;
    logic [flit_width_p-1:0] data;
    logic                    ready_and_rev;
  } link_s;

  typedef enum logic [1:0] {e_ready, e_body, e_drain, e_out} state_e;

  localparam logic [len_width_p-1:0] one_lp     = len_width_p'(1);
  localparam logic [len_width_p-1:0] max_len_lp = len_width_p'(max_body_flits_p);

  link_s link_in, link_out;
  assign link_in = link_i;
  assign link_o  = link_out;

  // The reverse-channel bit of the incoming link belongs to the upstream sender.
  logic unused_ready_and_rev;
  assign unused_ready_and_rev = link_in.ready_and_rev;

  state_e                     state_q, state_d;
  logic [len_width_p-1:0]     count_q, count_d;
  logic [len_width_p-1:0]     len_q,   len_d;
  logic [packet_width_lp-1:0] buf_q,   buf_d;
  logic                       err_q,   err_d;

  logic                   ready_and_rev;
  logic                   flit_xfer;
  logic [len_width_p-1:0] hdr_len;

  assign flit_xfer = link_in.v & ready_and_rev;
  assign hdr_len   = link_in.data[cord_width_p +: len_width_p];

  // State register
  always_ff @(posedge io_clk_i) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (!io_reset_n_i) begin
      state_q <= e_ready;
      count_q <= '0;
      len_q   <= '0;
      // NOTE: the packet buffer is reset so nothing from an aborted packet can leak out.
      buf_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      len_q   <= len_d;
      buf_q   <= buf_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: every target holds its value by default, so no path can infer a latch.
    state_d = state_q;
    count_d = count_q;
    len_d   = len_q;
    buf_d   = buf_q;
    err_d   = err_q;
    unique case (state_q)
      e_ready: begin
        if (flit_xfer) begin
          buf_d                      = '0;
          buf_d[0 +: flit_width_p]   = link_in.data;
          len_d                      = hdr_len;
          count_d                    = '0;
          if (hdr_len == '0) begin
            state_d = e_out;
          end else if (hdr_len <= max_len_lp) begin
            state_d = e_body;
          end else begin
            state_d = e_drain;
            err_d   = 1'b1;
          end
        end
      end
      e_body: begin
        if (flit_xfer) begin
          for (int k = 1; k <= max_body_flits_p; k++) begin
            if (len_width_p'(k) == count_q + one_lp) begin
              buf_d[k*flit_width_p +: flit_width_p] = link_in.data;
            end
          end
          count_d = count_q + one_lp;
          if (count_q == len_q - one_lp) state_d = e_out;
        end
      end
      e_drain: begin
        if (flit_xfer) begin
          count_d = count_q + one_lp;
          if (count_q == len_q - one_lp) state_d = e_ready;
        end
      end
      e_out: begin
        if (packet_yumi_i) state_d = e_ready;
      end
      default: state_d = e_ready;
    endcase
  end

  // Output logic; the link is never ready while in reset or while a packet is held
  always_comb begin
    ready_and_rev = 1'b0;
    packet_v_o    = 1'b0;
    unique case (state_q)
      e_ready, e_body, e_drain: ready_and_rev = io_reset_n_i;
      e_out:                    packet_v_o    = 1'b1;
      default: begin
        ready_and_rev = 1'b0;
        packet_v_o    = 1'b0;
      end
    endcase
  end

  assign link_out     = '{v: 1'b0, data: '0, ready_and_rev: ready_and_rev};
  assign packet_o     = buf_q;
  assign packet_len_o = len_q;
  assign err_o        = err_q;

  yumi_only_when_valid: assert property (
    @(posedge io_clk_i) disable iff (!io_reset_n_i) packet_yumi_i |-> packet_v_o
  );

endmodule

// File: tb/tb_bp_io_wormhole_packet_assembler.sv
// Scoreboard bench for the IO packet assembler: a driver pushes expected packets,
// an independent monitor pops and compares each presented packet.
module tb_bp_io_wormhole_packet_assembler;

  localparam int FW = 64;
  localparam int LW = 4;
  localparam int PW = FW * 8;

  typedef struct {
    logic [PW-1:0] data;
    logic [LW-1:0] len;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [FW+1:0] link_i, link_o;
  logic [PW-1:0] packet_o;
  logic [LW-1:0] packet_len_o;
  logic          packet_v_o, packet_yumi_i, err_o;
  logic          in_v;
  logic [FW-1:0] in_data;
  logic          ready;

  assign link_i = {in_v, in_data, 1'b0};
  assign ready  = link_o[0];

  always #5 clk = ~clk;

  bp_io_wormhole_packet_assembler dut (
    .io_clk_i      (clk),
    .io_reset_n_i  (rst_n),
    .link_i        (link_i),
    .link_o        (link_o),
    .packet_o      (packet_o),
    .packet_len_o  (packet_len_o),
    .packet_v_o    (packet_v_o),
    .packet_yumi_i (packet_yumi_i),
    .err_o         (err_o)
  );

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          fixed_delay;
  logic        exp_err;
  logic [FW-1:0] f[16];

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  function automatic logic [FW-1:0] make_header(input int len);
    logic [FW-1:0] h;
    h = {$urandom, $urandom};
    h[11:8] = 4'(len);
    return h;
  endfunction

  // Reference packet: header in flit 0, body k in flit k, all unused flits zero.
  task automatic push_exp(input int len);
    exp_t e;
    e.data = '0;
    for (int k = 0; k <= len; k++) e.data[k*FW +: FW] = f[k];
    e.len = 4'(len);
    exp_q.push_back(e);
  endtask

  task automatic bubble(input int n);
    repeat (n) begin
      @(negedge clk);
      in_v    = 1'b0;
      in_data = {$urandom, $urandom};
    end
  endtask

  task automatic drive_flit(input logic [FW-1:0] d);
    int guard = 0;
    forever begin
      @(negedge clk);
      in_v    = 1'b1;
      in_data = d;
      if (ready) begin
        @(posedge clk);
        #1 in_v = 1'b0;
        return;
      end
      guard++;
      if (guard > 2000) begin
        n_cmp++;
        n_fail++;
        $display("FAIL flit_accept_timeout: got no ready in %0d cycles, required ready", guard);
        in_v = 1'b0;
        return;
      end
    end
  endtask

  task automatic send_packet(input int len, input int bub_max);
    push_exp(len);
    for (int k = 0; k <= len; k++) begin
      if (bub_max > 0) bubble($urandom_range(0, bub_max));
      drive_flit(f[k]);
    end
  endtask

  task automatic wait_drain();
    int guard = 0;
    @(negedge clk);
    while (exp_q.size() != 0 || packet_v_o) begin
      guard++;
      if (guard > 300) begin
        n_cmp++;
        n_fail++;
        $display("FAIL drain_timeout: got %0d packets pending, required 0", exp_q.size());
        return;
      end
      @(negedge clk);
    end
  endtask

  // Monitor: pops one expectation per presented packet, holds it until yumi.
  initial begin
    exp_t cur;
    bit   have;
    int   wl;
    have = 0;
    wl   = 0;
    packet_yumi_i = 1'b0;
    forever begin
      @(negedge clk);
      packet_yumi_i = 1'b0;
      if (packet_v_o) begin
        if (!have) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_packet: got packet len %0d, required no packet", packet_len_o);
            packet_yumi_i = 1'b1;
            continue;
          end
          cur  = exp_q.pop_front();
          have = 1;
          wl   = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
        end
        check("packet_data", packet_o, cur.data);
        check("packet_len", PW'(packet_len_o), PW'(cur.len));
        check("ready_while_valid", PW'(ready), '0);
        check("err_while_valid", PW'(err_o), PW'(exp_err));
        check("link_o_tied", PW'(link_o[FW+1:1]), '0);
        if (wl == 0) begin
          packet_yumi_i = 1'b1;
          have = 0;
        end else begin
          wl--;
        end
      end
    end
  end

  initial begin
    #800_000;
    n_cmp++;
    n_fail++;
    $display("FAIL global_timeout: got no end of test, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    rst_n       = 1'b0;
    in_v        = 1'b0;
    in_data     = '0;
    fixed_delay = -1;
    exp_err     = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_ready", PW'(ready), '0);
    check("reset_valid", PW'(packet_v_o), '0);
    check("reset_err", PW'(err_o), '0);
    check("reset_packet", packet_o, '0);
    rst_n = 1'b1;

    // Zero-length packet
    f[0] = 64'h0000_0000_0000_0005;
    send_packet(0, 0);
    wait_drain();
    check("ready_after_yumi", PW'(ready), PW'(1));

    // len=3 with a bubble between the first two body flits
    f[0] = make_header(3);
    f[1] = 64'hA1;
    f[2] = 64'hA2;
    f[3] = 64'hA3;
    push_exp(3);
    drive_flit(f[0]);
    drive_flit(f[1]);
    bubble(1);
    drive_flit(f[2]);
    drive_flit(f[3]);
    wait_drain();

    // Two max-length packets back to back, consumer stalls 5 cycles each
    fixed_delay = 5;
    for (int p = 0; p < 2; p++) begin
      f[0] = make_header(7);
      for (int k = 1; k <= 7; k++) f[k] = {$urandom, $urandom};
      send_packet(7, 0);
    end
    wait_drain();
    fixed_delay = -1;

    // Oversize header is drained and flagged, then a legal packet follows
    f[0] = make_header(9);
    drive_flit(f[0]);
    exp_err = 1'b1;
    check("err_after_oversize_hdr", PW'(err_o), PW'(1));
    for (int k = 1; k <= 9; k++) drive_flit({$urandom, $urandom});
    f[0] = make_header(1);
    f[1] = {$urandom, $urandom};
    send_packet(1, 0);
    wait_drain();
    check("err_sticky", PW'(err_o), PW'(1));

    // Reset in the middle of a body
    f[0] = make_header(4);
    drive_flit(f[0]);
    drive_flit({$urandom, $urandom});
    drive_flit({$urandom, $urandom});
    @(negedge clk);
    rst_n = 1'b0;
    in_v  = 1'b0;
    @(posedge clk);
    #1;
    exp_err = 1'b0;
    check("midreset_ready", PW'(ready), '0);
    check("midreset_valid", PW'(packet_v_o), '0);
    check("midreset_err", PW'(err_o), '0);
    check("midreset_packet", packet_o, '0);
    check("midreset_len", PW'(packet_len_o), '0);
    @(negedge clk);
    rst_n = 1'b1;
    f[0] = make_header(0);
    send_packet(0, 0);
    wait_drain();

    // Random traffic
    for (int p = 0; p < 1000; p++) begin
      int len;
      len  = $urandom_range(0, 7);
      f[0] = make_header(len);
      for (int k = 1; k <= len; k++) f[k] = {$urandom, $urandom};
      send_packet(len, 2);
    end
    wait_drain();
    check("err_after_random", PW'(err_o), '0);
    check("queue_empty", PW'(exp_q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bp_io_wormhole_packet_assembler.md
Name: bp_io_wormhole_packet_assembler

Overview:
- Terminates one edge port of the IO NoC cmd/resp network, which is a row of IO tiles joined by a mesh stitch, and feeds the off-chip/host-side consumer.
- Accepts wormhole flits on a ready-and link, reassembles each header + body sequence into one wide packet, and presents it with a valid/yumi handshake.
- Oversized packets are drained and flagged, never forwarded.

Parameters:
- flit_width_p, 64: width of one NoC flit.
- cord_width_p, 8: destination cord field, header bits [cord_width_p-1:0].
- len_width_p, 4: body-flit count field, header bits [cord_width_p+len_width_p-1:cord_width_p].
- max_body_flits_p, 7: largest legal body length.
- packet_width_lp (local), flit_width_p*(max_body_flits_p+1): width of the assembled packet.

Ports:
- io_clk_i, input, 1: single clock.
- io_reset_n_i, input, 1: synchronous, active-low reset.
- link_i, input, flit_width_p+2: packed ready-and link struct {v, data[flit_width_p-1:0], ready_and_rev}. Only v and data are used.
- link_o, output, flit_width_p+2: packed ready-and link struct. Only ready_and_rev is driven; v and data are tied to 0.
- packet_o, output, packet_width_lp: flit k in bits [k*flit_width_p +: flit_width_p]. Flit 0 is the header. Unused flits are 0.
- packet_len_o, output, len_width_p: body length of the presented packet.
- packet_v_o, output, 1: packet valid.
- packet_yumi_i, input, 1: consumer takes the packet. Legal only while packet_v_o=1.
- err_o, output, 1: sticky oversize-packet flag.

Behaviour:
- Flit transfer: a flit moves only when link_i.v & link_o.ready_and_rev in the same cycle.
- Reset (io_reset_n_i=0 at a clock edge): state=e_ready, count=0, packet buffer=0, packet_v_o=0, err_o=0, link_o.ready_and_rev=0 during reset.
  - Reset mid-packet discards all partial state.
  - Flits that arrive after reset deasserts are treated as a new header.
- State e_ready:
  - ready_and_rev=1.
  - On header transfer, header goes to buffer flit 0, flits 1..max are zeroed, and len is latched.
  - len==0: next state e_out.
  - 1<=len<=max_body_flits_p: next state e_body, count=0.
  - len>max_body_flits_p: next state e_drain, count=0, err_o<=1.
- State e_body:
  - ready_and_rev=1.
  - Each transfer writes flit count+1 and increments count.
  - The transfer with count==len-1 moves to e_out.
  - Bubbles (v=0) hold all state.
- State e_drain:
  - ready_and_rev=1.
  - Transfers are discarded and count increments.
  - The transfer with count==len-1 returns to e_ready.
  - packet_v_o stays 0 throughout.
- State e_out:
  - packet_v_o=1 and ready_and_rev=0.
  - packet_o and packet_len_o hold stable until yumi.
  - packet_yumi_i=1 returns to e_ready next cycle.
  - No header is accepted in the yumi cycle.
- Latency:
  - packet_v_o rises the cycle after the last flit transfers.
  - Minimum occupancy per packet is len+2 cycles (header cycle, len body cycles, one out cycle with immediate yumi).
- Counter: count is len_width_p bits. len is at most 2^len_width_p-1, so the count never wraps within a packet.
- err_o: set only by an oversize header. Cleared only by reset. It does not block later packets.
- packet_yumi_i outside e_out is an assertion error and is otherwise ignored.
- link_o.v and link_o.data are always 0.

Test Plan:
- Reset, then header 0x0000_0000_0000_0005 (cord=5, len=0) → next cycle packet_v_o=1, packet_o flit0=0x...05, other flits 0, packet_len_o=0. yumi → e_ready, ready_and_rev=1 the following cycle.
- Header with len=3 followed by flits 0xA1, 0xA2, 0xA3, with one v=0 bubble between A1 and A2 → packet_v_o rises 1 cycle after A3 with flits 1..3=A1..A3, flits 4..7=0, len=3. ready_and_rev=0 while valid.
- Max packet len=7 back-to-back, consumer holds yumi=0 for 5 cycles → packet_o stable for all 5 cycles. ready_and_rev=0 throughout. After yumi, a second len=7 packet is received intact.
- Oversize header len=9 plus 9 body flits, then a legal len=1 packet → err_o=1 from the cycle after the header, no packet_v_o for the oversize packet, legal packet delivered correctly, err_o still 1.
- Reset asserted after 2 of 4 body flits → all outputs 0 next cycle. A fresh len=0 packet after release delivers with no stale data from the aborted packet.
- Random: 1000 packets with random len 0..7, random bubbles and random yumi delay → scoreboard matches every packet in order with no loss or duplication. err_o stays 0.
